stoch_arith_unit: RTL and testbench
===================================

# stoch_arith_unit

Parametrised stochastic-computing arithmetic core: two LFSR-driven stochastic number generators (SNGs), a mode-selectable stochastic combiner (unipolar multiply, bipolar multiply, scaled add, pass-through) and a windowed up-counter that converts the output stream back to binary. It generalises the fixed 4-bit bipolar multiplier with its 8-cycle counter: the operand width, window length, LFSR seeds and operation mode are all configurable. The full count is representable, so there is no overflow case. It sits between the tile's operand inputs and the binary result pins.

## Interface
- N, 4: operand/probability width; legal 2..16.
- WIN_LOG2, 3: window length L = 2^WIN_LOG2 stream bits; legal 1..12.
- SEED_A, 31'd1: LFSR A reset value; non-zero, elaboration error otherwise.
- SEED_B, 31'd2: LFSR B reset value; non-zero, must differ from SEED_A.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  advance enable; low freezes all state.
- mode  input  2  00 unipolar AND, 01 bipolar XNOR, 10 scaled add (MUX), 11 pass A.
- prob_a  input  N  operand A probability, value/2^N.
- prob_b  input  N  operand B probability, value/2^N.
- sn_out  output  1  combined stochastic bit (stage-2 register).
- result  output  WIN_LOG2+1  count of ones in last completed window, 0..L.
- result_valid  output  1  one-cycle pulse when result updates.

## Operation
- LFSRs: 31-bit Fibonacci, taps x^31+x^28+1; on each en cycle q <= {q[29:0], q[30]^q[27]}. Both advance together.
- Stage 0 (issue): when en=1, sn_a <= (lfsr_a[N-1:0] < pa), sn_b <= (lfsr_b[N-1:0] < pb), sel <= lfsr_b[30], v1 <= 1, last1 <= (issue_idx == L-1), mode1 <= m.
- Operand latching: at issue_idx 0, pa/pb/m take prob_a/prob_b/mode directly and are loaded into shadow registers; at issue_idx 1..L-1, shadows are used. Port changes mid-window have no effect until the next window.
- issue_idx: WIN_LOG2-bit counter, increments each en cycle, wraps L-1 -> 0.
- Stage 1 (combine): sn_out <= f(mode1); AND: a&b; XNOR: ~(a^b); MUX: sel ? b : a; pass: a. Propagates v2/last2.
- Stage 2 (count): when v2, acc_next = acc + sn_out. If last2: result <= acc_next, result_valid <= 1, acc <= 0; else acc <= acc_next.
- acc and result are WIN_LOG2+1 bits wide; an all-ones window yields result = L exactly, with no wrap.
- en=0: LFSRs, shadows, pipeline, acc and issue_idx hold; result holds; result_valid is 0.
- Reset values: LFSRs = seeds; sn_a, sn_b, sn_out, v1, v2, last flags, acc, issue_idx, shadows, result, result_valid = 0.

## Timing
- Pipeline latency: an issue at edge t is counted at edge t+2.
- First result: with en held high from edge t0 after reset release, result_valid is high after edge t0+L+1, i.e. after L+2 enabled edges.
- Thereafter result_valid pulses exactly every L enabled cycles; it is never high on two consecutive cycles when L ≥ 2.
- en gaps stretch the latency by the gap length; no bits are lost or duplicated.
- Asynchronous reset mid-window: all state returns to reset values immediately, the partial window is discarded, and the next window starts at issue_idx 0.
- The result update and the first acc increment of the next window never collide, because acc is cleared on the last edge.

## Test plan
- Defaults, mode 00, prob_a=0, prob_b=15 -> every result = 0; first result_valid after 10 enabled edges, then every 8.
- Mode 01, prob_a=0, prob_b=0 -> both streams all zero, XNOR all ones; result = 8 each window, no wrap to 0.
- Mode 11, prob_a=0, then prob_a=15 changed at issue_idx 3 -> current window result 0; the change takes effect in the next window only.
- en toggled low for 5 cycles mid-window, mode 01, prob_a=prob_b=0 -> result still 8; result_valid arrives 5 cycles later than it would without the gap.
- rst_n asserted at issue_idx 5 -> result=0, result_valid=0, sn_out=0 immediately; after release, first valid after L+2 enabled edges.
- N=8, WIN_LOG2=10, mode 00, prob_a=prob_b=128 -> result within 256±48 over 16 windows; the LFSR sequence matches the reference model bit for bit.

Source files
------------

// File: rtl/stoch_arith_unit.sv
// Stochastic arithmetic core: two LFSR-driven number generators, a mode-selectable
// bitstream combiner and a windowed ones-counter that converts the stream back to binary.
module stoch_arith_unit #(
  parameter int          N        = 4,
  parameter int          WIN_LOG2 = 3,
  parameter logic [30:0] SEED_A   = 31'd1,
  parameter logic [30:0] SEED_B   = 31'd2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [N-1:0]        prob_a,
  input  logic [N-1:0]        prob_b,
  output logic                sn_out,
  output logic [WIN_LOG2:0]   result,
  output logic                result_valid
);

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_XNOR = 2'b01,
    MODE_MUX  = 2'b10,
    MODE_PASS = 2'b11
  } mode_e;

  if (N < 2 || N > 16) begin : g_bad_n
    $error("stoch_arith_unit: N must be in 2..16");
  end
  if (WIN_LOG2 < 1 || WIN_LOG2 > 12) begin : g_bad_win
    $error("stoch_arith_unit: WIN_LOG2 must be in 1..12");
  end
  if (SEED_A == 31'd0 || SEED_B == 31'd0) begin : g_bad_seed_zero
    $error("stoch_arith_unit: LFSR seeds must be non-zero");
  end
  if (SEED_A == SEED_B) begin : g_bad_seed_same
    $error("stoch_arith_unit: SEED_A and SEED_B must differ");
  end

  logic [30:0]         r_lfsr_a;
  logic [30:0]         r_lfsr_b;
  logic [WIN_LOG2-1:0] r_issue_idx;
  logic [N-1:0]        r_pa_sh;
  logic [N-1:0]        r_pb_sh;
  logic [1:0]          r_mode_sh;
  logic                r_sn_a;
  logic                r_sn_b;
  logic                r_sel;
  logic                r_v1;
  logic                r_last1;
  mode_e               r_mode1;
  logic                r_sn_out;
  logic                r_v2;
  logic                r_last2;
  logic [WIN_LOG2:0]   r_acc;
  logic [WIN_LOG2:0]   r_result;
  logic                r_result_valid;

  logic                w_first;
  logic [N-1:0]        w_pa;
  logic [N-1:0]        w_pb;
  logic [1:0]          w_mode;
  logic                w_comb;
  logic [WIN_LOG2:0]   w_acc_next;

  // Operands are sampled straight from the ports on the first bit of a window
  // and from the shadows afterwards, so mid-window port changes are ignored.
  always_comb begin
    w_first = (r_issue_idx == '0);
    w_pa    = w_first ? prob_a : r_pa_sh;
    w_pb    = w_first ? prob_b : r_pb_sh;
    w_mode  = w_first ? mode   : r_mode_sh;
  end

  always_comb begin
    w_comb = r_sn_a;
    case (r_mode1)
      MODE_AND:  w_comb = r_sn_a & r_sn_b;
      MODE_XNOR: w_comb = ~(r_sn_a ^ r_sn_b);
      MODE_MUX:  w_comb = r_sel ? r_sn_b : r_sn_a;
      MODE_PASS: w_comb = r_sn_a;
      default:   w_comb = r_sn_a;
    endcase
  end

  assign w_acc_next = r_acc + {{WIN_LOG2{1'b0}}, r_sn_out};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr_a       <= SEED_A;
      r_lfsr_b       <= SEED_B;
      r_issue_idx    <= '0;
      r_pa_sh        <= '0;
      r_pb_sh        <= '0;
      r_mode_sh      <= 2'b00;
      r_sn_a         <= 1'b0;
      r_sn_b         <= 1'b0;
      r_sel          <= 1'b0;
      r_v1           <= 1'b0;
      r_last1        <= 1'b0;
      r_mode1        <= MODE_AND;
      r_sn_out       <= 1'b0;
      r_v2           <= 1'b0;
      r_last2        <= 1'b0;
      r_acc          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      if (en) begin
        r_lfsr_a    <= {r_lfsr_a[29:0], r_lfsr_a[30] ^ r_lfsr_a[27]};
        r_lfsr_b    <= {r_lfsr_b[29:0], r_lfsr_b[30] ^ r_lfsr_b[27]};
        r_issue_idx <= r_issue_idx + 1'b1;
        if (w_first) begin
          r_pa_sh   <= prob_a;
          r_pb_sh   <= prob_b;
          r_mode_sh <= mode;
        end

        r_sn_a  <= (r_lfsr_a[N-1:0] < w_pa);
        r_sn_b  <= (r_lfsr_b[N-1:0] < w_pb);
        r_sel   <= r_lfsr_b[30];
        r_v1    <= 1'b1;
        r_last1 <= &r_issue_idx;
        r_mode1 <= mode_e'(w_mode);

        r_sn_out <= w_comb;
        r_v2     <= r_v1;
        r_last2  <= r_last1;

        // Clearing acc on the last bit lets the next window count from zero
        // on the very next edge without a bubble.
        if (r_v2) begin
          if (r_last2) begin
            r_result       <= w_acc_next;
            r_result_valid <= 1'b1;
            r_acc          <= '0;
          end else begin
            r_acc <= w_acc_next;
          end
        end
      end
    end
  end

  assign sn_out       = r_sn_out;
  assign result       = r_result;
  assign result_valid = r_result_valid;

endmodule

// File: tb/tb_stoch_arith_unit.sv
// Directed bench for stoch_arith_unit: default 4-bit/8-bit-window instance plus an
// 8-bit/1024-bit-window instance checked against a bit-exact LFSR reference.
module tb_stoch_arith_unit;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [3:0] prob_a;
  logic [3:0] prob_b;
  logic       sn_out;
  logic [3:0] result;
  logic       result_valid;

  logic        rst8_n;
  logic        en8;
  logic [1:0]  mode8;
  logic [7:0]  pa8;
  logic [7:0]  pb8;
  logic        sn8;
  logic [10:0] res8;
  logic        rv8;

  int total = 0;
  int bad   = 0;

  localparam logic [30:0] WSEED_A = 31'h1A3C96E1;
  localparam logic [30:0] WSEED_B = 31'h2B7D4C19;

  stoch_arith_unit dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .prob_a(prob_a), .prob_b(prob_b),
    .sn_out(sn_out), .result(result), .result_valid(result_valid)
  );

  stoch_arith_unit #(.N(8), .WIN_LOG2(10), .SEED_A(WSEED_A), .SEED_B(WSEED_B)) dut8 (
    .clk(clk), .rst_n(rst8_n), .en(en8), .mode(mode8),
    .prob_a(pa8), .prob_b(pb8),
    .sn_out(sn8), .result(res8), .result_valid(rv8)
  );

  function automatic logic [30:0] lfsr_next(input logic [30:0] q);
    return {q[29:0], q[30] ^ q[27]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    tick();
    tick();
  endtask

  // Called just after an edge: the following edge is the first enabled one.
  task automatic start(input logic [1:0] m, input logic [3:0] pa, input logic [3:0] pb);
    mode   = m;
    prob_a = pa;
    prob_b = pb;
    en     = 1'b1;
    rst_n  = 1'b1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!result_valid && n < 64);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 2'b01; prob_a = 4'd0; prob_b = 4'd0;
    tick();
    total++; if (result !== 4'd0)      begin bad++; $display("FAIL reset_result got=%0d want=0", result); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", result_valid); end
    total++; if (sn_out !== 1'b0)      begin bad++; $display("FAIL reset_sn_out got=%b want=0", sn_out); end
    $display("test_reset: result=%0d valid=%b sn_out=%b", result, result_valid, sn_out);
  endtask

  task automatic test_first_valid();
    int n;
    do_reset();
    start(2'b00, 4'd0, 4'd15);
    wait_valid(n);
    total++; if (n !== 10)       begin bad++; $display("FAIL first_latency got=%0d want=10", n); end
    total++; if (result !== 4'd0) begin bad++; $display("FAIL and_zero_w0 got=%0d want=0", result); end
    $display("test_first_valid: latency=%0d result=%0d", n, result);
    for (int w = 1; w <= 2; w++) begin
      wait_valid(n);
      total++; if (n !== 8)        begin bad++; $display("FAIL period_w%0d got=%0d want=8", w, n); end
      total++; if (result !== 4'd0) begin bad++; $display("FAIL and_zero_w%0d got=%0d want=0", w, result); end
      $display("test_first_valid: window=%0d period=%0d result=%0d", w, n, result);
    end
  endtask

  task automatic test_bipolar_full();
    int n;
    do_reset();
    start(2'b01, 4'd0, 4'd0);
    for (int w = 0; w < 2; w++) begin
      wait_valid(n);
      total++; if (result !== 4'd8) begin bad++; $display("FAIL xnor_full_w%0d got=%0d want=8", w, result); end
      $display("test_bipolar_full: window=%0d result=%0d", w, result);
    end
  endtask

  // Window-0 results for the default seeds: lfsr_a low nibbles 1,2,4,8,0,0,0,0,
  // lfsr_b low nibbles 2,4,8,0,0,0,0,0, lfsr_b[30] stays 0.
  task automatic test_modes();
    logic [1:0] tm [6] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [3:0] ta [6] = '{4'd15, 4'd15, 4'd15, 4'd0, 4'd15, 4'd15};
    logic [3:0] tb [6] = '{4'd15, 4'd0, 4'd15, 4'd15, 4'd0, 4'd0};
    logic [3:0] te [6] = '{4'd8, 4'd0, 4'd8, 4'd0, 4'd8, 4'd8};
    int n;
    for (int i = 0; i < 6; i++) begin
      do_reset();
      start(tm[i], ta[i], tb[i]);
      wait_valid(n);
      total++;
      if (result !== te[i]) begin
        bad++;
        $display("FAIL mode_vec%0d got=%0d want=%0d", i, result, te[i]);
      end
      $display("test_modes: mode=%b pa=%0d pb=%0d result=%0d", tm[i], ta[i], tb[i], result);
    end
  endtask

  task automatic test_pass_latch();
    int n;
    do_reset();
    start(2'b11, 4'd0, 4'd0);
    tick(); tick(); tick();
    prob_a = 4'd15;
    wait_valid(n);
    total++; if (result !== 4'd0) begin bad++; $display("FAIL latch_cur_window got=%0d want=0", result); end
    $display("test_pass_latch: window=0 result=%0d", result);
    wait_valid(n);
    total++; if (result !== 4'd8) begin bad++; $display("FAIL latch_next_window got=%0d want=8", result); end
    $display("test_pass_latch: window=1 result=%0d", result);
  endtask

  task automatic test_en_gap();
    int n;
    int m;
    logic seen;
    do_reset();
    start(2'b01, 4'd0, 4'd0);
    seen = 1'b0;
    repeat (4) begin tick(); seen |= result_valid; end
    en = 1'b0;
    repeat (5) begin tick(); seen |= result_valid; end
    en = 1'b1;
    wait_valid(m);
    n = 9 + m;
    total++; if (seen !== 1'b0)    begin bad++; $display("FAIL gap_early_valid got=%b want=0", seen); end
    total++; if (n !== 15)         begin bad++; $display("FAIL gap_latency got=%0d want=15", n); end
    total++; if (result !== 4'd8)  begin bad++; $display("FAIL gap_result got=%0d want=8", result); end
    $display("test_en_gap: latency=%0d result=%0d", n, result);
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    start(2'b01, 4'd0, 4'd0);
    wait_valid(n);
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (result !== 4'd0)       begin bad++; $display("FAIL midrst_result got=%0d want=0", result); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", result_valid); end
    total++; if (sn_out !== 1'b0)       begin bad++; $display("FAIL midrst_sn_out got=%b want=0", sn_out); end
    $display("test_reset_mid: result=%0d valid=%b sn_out=%b", result, result_valid, sn_out);
    tick();
    start(2'b01, 4'd0, 4'd0);
    wait_valid(n);
    total++; if (n !== 10)        begin bad++; $display("FAIL midrst_latency got=%0d want=10", n); end
    total++; if (result !== 4'd8) begin bad++; $display("FAIL midrst_after got=%0d want=8", result); end
    $display("test_reset_mid: restart latency=%0d result=%0d", n, result);
  endtask

  task automatic test_wide();
    logic [30:0] ma;
    logic [30:0] mb;
    int exp;
    int n;
    int sum;
    ma = WSEED_A;
    mb = WSEED_B;
    sum = 0;
    rst8_n = 1'b0; en8 = 1'b0;
    tick();
    mode8 = 2'b00; pa8 = 8'd128; pb8 = 8'd128; en8 = 1'b1; rst8_n = 1'b1;
    for (int w = 0; w < 16; w++) begin
      exp = 0;
      for (int p = 0; p < 1024; p++) begin
        if ((ma[7:0] < 8'd128) && (mb[7:0] < 8'd128)) exp++;
        ma = lfsr_next(ma);
        mb = lfsr_next(mb);
      end
      n = 0;
      do begin
        tick();
        n++;
      end while (!rv8 && n < 1100);
      total++; if (rv8 !== 1'b1) begin bad++; $display("FAIL wide_timeout w=%0d waited=%0d", w, n); end
      total++;
      if (res8 !== exp[10:0]) begin
        bad++;
        $display("FAIL wide_result w=%0d got=%0d want=%0d", w, res8, exp);
      end
      sum += int'(res8);
      $display("test_wide: window=%0d result=%0d model=%0d", w, res8, exp);
    end
    total++;
    if (sum < 16 * 208 || sum > 16 * 304) begin
      bad++;
      $display("FAIL wide_mean got_sum=%0d want_range=%0d..%0d", sum, 16 * 208, 16 * 304);
    end
    en8 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; prob_a = 4'd0; prob_b = 4'd0;
    rst8_n = 1'b0; en8 = 1'b0; mode8 = 2'b00; pa8 = 8'd0; pb8 = 8'd0;
    test_reset();
    test_first_valid();
    test_bipolar_full();
    test_modes();
    test_pass_latch();
    test_en_gap();
    test_reset_mid();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
